vga_scaler: RTL and testbench

- Parametrised successor to the fixed 640x480 NES VGA output stage.
- Generates VGA timing from generics and centres an integer-scaled source window (SCALE x SCALE replication) in the active area.
- Produces framebuffer read addresses incrementally and converts 6-bit NES palette indices to RGB888, with all outputs pipeline-aligned.
- Sits between the frame buffer's read port and the DVI/VGA encoder, in a single pixel-clock domain with a clock enable.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/nes_palette.sv | 21 ++
 rtl/vga_scaler.sv | 199 +++++++++++++++++++
 tb/tb_vga_scaler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing, geometry helpers and the NES palette
// used by the scaled VGA output path.
package vga_pkg;

  typedef logic [23:0] rgb_t;

  // Per-pixel control flags carried down the pipeline beside the pixel data
  typedef struct packed {
    logic act;
    logic win;
    logic hsync;
    logic vsync;
    logic frame;
  } ctl_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int line_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int win_origin(input int act, input int src, input int scale);
    return (act - src * scale) / 2;
  endfunction

  localparam rgb_t NES_PAL [0:63] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

endpackage

// File: rtl/nes_palette.sv
// Registered 64-entry NES palette ROM: 6-bit index in, RGB888 out one CE tick later.
module nes_palette
  import vga_pkg::*;
(
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_CE,
  input  logic [5:0] I_IDX,
  output rgb_t       O_RGB
);

  rgb_t r_rgb;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET)   r_rgb <= '0;
    else if (I_CE) r_rgb <= NES_PAL[I_IDX];
  end

  assign O_RGB = r_rgb;

endmodule

// File: rtl/vga_scaler.sv
// Parametrised VGA timing with a centred SCALE x SCALE source window, incremental
// framebuffer addressing and NES palette output, 3 CE ticks counter-to-pixel.
// Define VGA_SCALER_SCANLINE_EN to halve RGB on the last replicated line of each source row.
module vga_scaler
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   SRC_W    = 256,
  parameter int   SRC_H    = 240,
  parameter int   SCALE    = 2,
  parameter rgb_t BORDER   = 24'h000000,
  parameter int   AW       = 16
) (
  input  logic          I_CLK,
  input  logic          I_RESET,
  input  logic          I_CE,
  input  logic [5:0]    I_PIXEL,
  output logic [AW-1:0] O_ADDR,
  output logic          O_HSYNC,
  output logic          O_VSYNC,
  output logic          O_BLANK,
  output logic [7:0]    O_RED,
  output logic [7:0]    O_GREEN,
  output logic [7:0]    O_BLUE,
  output logic          O_FRAME
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int X0      = win_origin(H_ACTIVE, SRC_W, SCALE);
  localparam int Y0      = win_origin(V_ACTIVE, SRC_H, SCALE);
  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 1);

  localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT   = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SB    = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SW    = HCW'(H_SYNC);
  localparam logic [HCW-1:0] WX0     = HCW'(X0);
  localparam logic [HCW-1:0] WXL     = HCW'(X0 + SRC_W * SCALE - 1);
  localparam logic [HCW-1:0] W_SPAN  = HCW'(SRC_W * SCALE);
  localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT   = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SB    = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SW    = VCW'(V_SYNC);
  localparam logic [VCW-1:0] WY0     = VCW'(Y0);
  localparam logic [VCW-1:0] H_SPAN  = VCW'(SRC_H * SCALE);
  localparam logic [1:0]     SC_LAST = 2'(SCALE - 1);
  localparam logic [AW-1:0]  LSTEP   = AW'(SRC_W);

  if (SRC_W * SCALE > H_ACTIVE) begin : g_err_w
    $error("vga_scaler: scaled source width exceeds H_ACTIVE");
  end
  if (SRC_H * SCALE > V_ACTIVE) begin : g_err_h
    $error("vga_scaler: scaled source height exceeds V_ACTIVE");
  end
  if (SCALE < 1 || SCALE > 4) begin : g_err_s
    $error("vga_scaler: SCALE must be 1..4");
  end
  if ((longint'(SRC_W) * longint'(SRC_H)) > (longint'(1) << AW)) begin : g_err_a
    $error("vga_scaler: source does not fit in AW address bits");
  end

  logic [HCW-1:0] r_hcnt;
  logic [VCW-1:0] r_vcnt;
  logic [1:0]     r_hs, r_vs;
  logic [AW-1:0]  r_line_base, r_addr;
  ctl_t           r_ctl [1:3];

  logic w_hwin, w_vwin, w_win;
  ctl_t w_ctl;
  rgb_t w_pal_rgb, w_rgb;

  // Unsigned wrap turns "lo <= x < lo+n" into a single compare
  assign w_hwin = (r_hcnt - WX0) < W_SPAN;
  assign w_vwin = (r_vcnt - WY0) < H_SPAN;
  assign w_win  = w_hwin && w_vwin;

  always_comb begin
    w_ctl       = '0;
    w_ctl.act   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    w_ctl.win   = w_win;
    w_ctl.hsync = (r_hcnt - H_SB) < H_SW;
    w_ctl.vsync = (r_vcnt - V_SB) < V_SW;
    w_ctl.frame = (r_hcnt == '0) && (r_vcnt == '0);
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (I_CE) begin
      r_hcnt <= (r_hcnt == H_LAST) ? '0 : r_hcnt + 1'b1;
      if (r_hcnt == H_LAST)
        r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end
  end

  // Address walks by SCALE-pixel steps; line_base steps one source row every SCALE lines
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_hs        <= '0;
      r_vs        <= '0;
      r_line_base <= '0;
      r_addr      <= '0;
    end else if (I_CE) begin
      if (w_win) begin
        if (r_hcnt == WX0) begin
          r_addr <= r_line_base;
          r_hs   <= '0;
        end else if (r_hs == SC_LAST) begin
          r_addr <= r_addr + 1'b1;
          r_hs   <= '0;
        end else begin
          r_hs <= r_hs + 1'b1;
        end
        if (r_hcnt == WXL) begin
          if (r_vs == SC_LAST) begin
            r_vs        <= '0;
            r_line_base <= r_line_base + LSTEP;
          end else begin
            r_vs <= r_vs + 1'b1;
          end
        end
      end
      if (!w_vwin) begin
        r_vs        <= '0;
        r_line_base <= '0;
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_ctl[1] <= '0;
      r_ctl[2] <= '0;
      r_ctl[3] <= '0;
    end else if (I_CE) begin
      r_ctl[1] <= w_ctl;
      r_ctl[2] <= r_ctl[1];
      r_ctl[3] <= r_ctl[2];
    end
  end

  nes_palette u_pal (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .I_CE    (I_CE),
    .I_IDX   (I_PIXEL),
    .O_RGB   (w_pal_rgb)
  );

`ifdef VGA_SCALER_SCANLINE_EN
  localparam logic DIM_OK = (SCALE >= 2);
  logic r_dim [1:3];

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_dim[1] <= 1'b0;
      r_dim[2] <= 1'b0;
      r_dim[3] <= 1'b0;
    end else if (I_CE) begin
      r_dim[1] <= DIM_OK && w_win && (r_vs == SC_LAST);
      r_dim[2] <= r_dim[1];
      r_dim[3] <= r_dim[2];
    end
  end

  always_comb begin
    w_rgb = '0;
    if (r_ctl[3].act) w_rgb = r_ctl[3].win ? w_pal_rgb : BORDER;
    if (r_ctl[3].act && r_ctl[3].win && r_dim[3])
      w_rgb = {1'b0, w_pal_rgb[23:17], 1'b0, w_pal_rgb[15:9], 1'b0, w_pal_rgb[7:1]};
  end
`else
  always_comb begin
    w_rgb = '0;
    if (r_ctl[3].act) w_rgb = r_ctl[3].win ? w_pal_rgb : BORDER;
  end
`endif

  assign O_ADDR  = r_addr;
  assign O_HSYNC = r_ctl[3].hsync ? SYNC_POL : ~SYNC_POL;
  assign O_VSYNC = r_ctl[3].vsync ? SYNC_POL : ~SYNC_POL;
  assign O_BLANK = ~r_ctl[3].act;
  assign O_FRAME = r_ctl[3].frame;
  assign O_RED   = w_rgb[23:16];
  assign O_GREEN = w_rgb[15:8];
  assign O_BLUE  = w_rgb[7:0];

endmodule

// File: tb/tb_vga_scaler.sv
// Bench for vga_scaler: two small-timing instances (SCALE 2 and SCALE 1) checked every
// cycle against a position-based model, plus hand-computed spot values.
module tb_vga_scaler;

  localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;   // 56
  localparam int VT = VA + VFP + VSY + VBP;   // 37
  localparam int FT = HT * VT;                // 2072
  localparam int SW = 16, SH = 12;
  localparam int SA = 2, XA = 4,  YA = 3;
  localparam int SB = 1, XB = 12, YB = 9;
  localparam logic [23:0] BORD_B = 24'h123456;

  localparam logic [23:0] PAL [0:63] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  typedef struct packed {
    logic        blank;
    logic        hs;
    logic        vs;
    logic        frm;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b0;
  logic [5:0]  pix_a = '0, pix_b = '0;
  logic [15:0] a_addr;
  logic [7:0]  b_addr;
  logic a_hs, a_vs, a_blank, a_frm, b_hs, b_vs, b_blank, b_frm;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

  int checks = 0, failures = 0;
  int k = 0, prev_k = 0, ea = 0, eb = 0;
  bit stats_en = 1'b0;
  int n_blank = 0, n_hs = 0, n_vs = 0, n_frm_a = 0, n_frm_b = 0;

  always #5 clk = ~clk;

  vga_scaler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b0), .SRC_W(SW), .SRC_H(SH), .SCALE(SA),
    .BORDER(24'h000000), .AW(16)
  ) u_a (
    .I_CLK(clk), .I_RESET(rst), .I_CE(ce), .I_PIXEL(pix_a), .O_ADDR(a_addr),
    .O_HSYNC(a_hs), .O_VSYNC(a_vs), .O_BLANK(a_blank),
    .O_RED(a_r), .O_GREEN(a_g), .O_BLUE(a_b), .O_FRAME(a_frm)
  );

  vga_scaler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b1), .SRC_W(SW), .SRC_H(SH), .SCALE(SB),
    .BORDER(BORD_B), .AW(8)
  ) u_b (
    .I_CLK(clk), .I_RESET(rst), .I_CE(ce), .I_PIXEL(pix_b), .O_ADDR(b_addr),
    .O_HSYNC(b_hs), .O_VSYNC(b_vs), .O_BLANK(b_blank),
    .O_RED(b_r), .O_GREEN(b_g), .O_BLUE(b_b), .O_FRAME(b_frm)
  );

  // Framebuffer model: synchronous read returning addr[5:0]
  always @(posedge clk) begin
    if (ce) begin
      pix_a <= a_addr[5:0];
      pix_b <= b_addr[5:0];
    end
  end

  // Count of CE ticks since reset release == live counter position
  always @(posedge clk or posedge rst) begin
    if (rst)     k <= 0;
    else if (ce) k <= k + 1;
  end

  function automatic int win_addr(input int p, input int s, input int x0, input int y0);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    if (h >= x0 && h < x0 + SW * s && v >= y0 && v < y0 + SH * s)
      return ((v - y0) / s) * SW + (h - x0) / s;
    return -1;
  endfunction

  function automatic exp_t model(input int p, input int s, input int x0, input int y0,
                                 input logic pol, input logic [23:0] bord);
    exp_t e;
    int h, v, a;
    logic [23:0] c;
    e = '{blank: 1'b1, hs: ~pol, vs: ~pol, frm: 1'b0, rgb: 24'h0};
    if (p < 0) return e;
    h = p % HT;
    v = (p / HT) % VT;
    a = win_addr(p, s, x0, y0);
    e.blank = !(h < HA && v < VA);
    e.hs    = (h >= HA + HFP && h < HA + HFP + HSY) ? pol : ~pol;
    e.vs    = (v >= VA + VFP && v < VA + VFP + VSY) ? pol : ~pol;
    e.frm   = (p % FT) == 0;
    if (!e.blank) begin
      if (a < 0) e.rgb = bord;
      else begin
        c = PAL[a % 64];
`ifdef VGA_SCALER_SCANLINE_EN
        if (s >= 2 && ((v - y0) % s) == s - 1)
          c = {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`endif
        e.rgb = c;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_a_addr"}, 32'(a_addr), 32'd0);
    chk({tag, "_a_ctl"}, {28'd0, a_blank, a_hs, a_vs, a_frm}, 32'b1110);
    chk({tag, "_a_rgb"}, {8'd0, a_r, a_g, a_b}, 32'd0);
    chk({tag, "_b_addr"}, 32'(b_addr), 32'd0);
    chk({tag, "_b_ctl"}, {28'd0, b_blank, b_hs, b_vs, b_frm}, 32'b1000);
    chk({tag, "_b_rgb"}, {8'd0, b_r, b_g, b_b}, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t xa, xb;
    int pa, pb;
    bit new_tick;
    if (!rst) begin
      new_tick = (k != prev_k);
      if (new_tick) begin
        if (k == 0) begin
          ea = 0;
          eb = 0;
        end else begin
          pa = win_addr(k - 1, SA, XA, YA);
          pb = win_addr(k - 1, SB, XB, YB);
          if (pa >= 0) ea = pa;
          if (pb >= 0) eb = pb;
        end
        prev_k = k;
      end
      xa = model(k - 3, SA, XA, YA, 1'b0, 24'h000000);
      xb = model(k - 3, SB, XB, YB, 1'b1, BORD_B);
      chk("a_addr", 32'(a_addr), 32'(ea));
      chk("a_ctl", {28'd0, a_blank, a_hs, a_vs, a_frm}, {28'd0, xa.blank, xa.hs, xa.vs, xa.frm});
      chk("a_rgb", {8'd0, a_r, a_g, a_b}, {8'd0, xa.rgb});
      chk("b_addr", 32'(b_addr), 32'(eb));
      chk("b_ctl", {28'd0, b_blank, b_hs, b_vs, b_frm}, {28'd0, xb.blank, xb.hs, xb.vs, xb.frm});
      chk("b_rgb", {8'd0, b_r, b_g, b_b}, {8'd0, xb.rgb});

      if (new_tick && stats_en && k >= 3 && k < 3 + FT) begin
        if (!a_blank) n_blank++;
        if (!a_hs)    n_hs++;
        if (!a_vs)    n_vs++;
        if (a_frm)    n_frm_a++;
        if (b_frm)    n_frm_b++;
      end

      if (new_tick) begin
        case (k)
          3: begin
            chk("lit_a_frame", 32'(a_frm), 32'd1);
            chk("lit_a_border", {8'd0, a_r, a_g, a_b}, 32'h000000);
            chk("lit_b_border", {8'd0, b_r, b_g, b_b}, 32'h123456);
          end
          47: begin
            chk("lit_a_hsync_lo", 32'(a_hs), 32'd0);
            chk("lit_b_hsync_hi", 32'(b_hs), 32'd1);
          end
          175:  chk("lit_a_first_pix", {8'd0, a_r, a_g, a_b}, 32'h7C7C7C);
          177:  chk("lit_a_pix1", {8'd0, a_r, a_g, a_b}, 32'h0000FC);
          229:  chk("lit_a_repl_line_addr0", 32'(a_addr), 32'd0);
          231:  chk("lit_a_repl_line_addr1", 32'(a_addr), 32'd1);
          285:  chk("lit_a_line2_addr", 32'(a_addr), 32'd16);
          287:  chk("lit_a_line2_pix", {8'd0, a_r, a_g, a_b}, 32'hBCBCBC);
          511:  chk("lit_a_even_30", {8'd0, a_r, a_g, a_b}, 32'hFCFCFC);
          519:  chk("lit_b_first_pix", {8'd0, b_r, b_g, b_b}, 32'h7C7C7C);
          520:  chk("lit_b_pix1", {8'd0, b_r, b_g, b_b}, 32'h0000FC);
`ifdef VGA_SCALER_SCANLINE_EN
          567:  chk("lit_a_odd_30", {8'd0, a_r, a_g, a_b}, 32'h7E7E7E);
`else
          567:  chk("lit_a_odd_30", {8'd0, a_r, a_g, a_b}, 32'hFCFCFC);
`endif
          573:  chk("lit_b_line1_addr", 32'(b_addr), 32'd16);
          1461: chk("lit_a_last_line_addr", 32'(a_addr), 32'd176);
          2245: chk("lit_a_next_frame_addr", 32'(a_addr), 32'd0);
          default: ;
        endcase
      end
    end
  end

  initial begin
    bit found;
    repeat (4) @(negedge clk);
    reset_checks("rst0");
    ce = 1'b1;
    rst = 1'b0;
    stats_en = 1'b1;
    repeat (4500) @(negedge clk);
    stats_en = 1'b0;
    chk("frame_blank_low", 32'(n_blank), 32'(HA * VA));
    chk("frame_hsync_cnt", 32'(n_hs), 32'(HSY * VT));
    chk("frame_vsync_cnt", 32'(n_vs), 32'(VSY * HT));
    chk("frame_pulse_a", 32'(n_frm_a), 32'd1);
    chk("frame_pulse_b", 32'(n_frm_b), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ce = ~ce;
    end

    @(negedge clk);
    ce = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 * FT && !found; i++) begin
      @(negedge clk);
      if ((k % HT) == 25 && ((k / HT) % VT) == 20) found = 1'b1;
    end
    chk("midrst_reach", 32'(found), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_checks("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2500) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
